paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_H, 600, visible screen height in pixels.
REQ-002 SHALL have parameter PADDLE_H, 80, paddle height in pixels.
REQ-003 SHALL have parameter Y_INIT, 260, paddle top-edge row after reset.
REQ-004 SHALL have parameter STEP, 4, pixels moved per frame tick at base speed.
REQ-005 SHALL have parameter GLIDE_FRAMES, 8, frame ticks of motion per accepted press.
REQ-006 SHALL have port clk  input  1  system clock.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-009 SHALL have port btn_up  input  1  one-cycle press pulse, move paddle up (towards row 0).
REQ-010 SHALL have port btn_down  input  1  one-cycle press pulse, move paddle down.
REQ-011 SHALL have port freeze  input  1  level; hold paddle (serve/pause).
REQ-012 SHALL have port paddle_y  output  11  paddle top-edge row, registered.
REQ-013 SHALL have port moving  output  1  high when state is MOVE_UP or MOVE_DOWN.
REQ-014 SHALL have port hit_wall  output  1  one-cycle pulse when a move is clamped at a bound.

Function
REQ-015 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN with a glide counter of width clog2(GLIDE_FRAMES+1).
REQ-016 SHALL, on a press (exactly one of btn_up/btn_down high, freeze low), enter the pressed direction's MOVE state and load glide counter with GLIDE_FRAMES, from any state.
REQ-017 SHALL ignore a cycle with btn_up and btn_down both high (no state, counter or position change from presses).
REQ-018 SHALL, on frame_tick in a MOVE state with freeze low, move paddle_y by the current step in the pre-cycle direction and decrement the counter; counter reaching 0 returns to IDLE.
REQ-019 SHALL, when a press and frame_tick coincide, apply the move using the pre-cycle state, then take state and counter from the press (reload overrides decrement).
REQ-020 SHALL clamp paddle_y to [0, SCREEN_H-PADDLE_H]; a move that reaches or would cross a bound sets paddle_y to the bound, pulses hit_wall for one cycle, enters IDLE, clears counter.
REQ-021 SHALL, while freeze is high, hold paddle_y, state and counter, ignore presses, and keep hit_wall low.
REQ-022 SHALL compute position arithmetic at 12 bits signed before clamping so no wrap-around occurs.
REQ-023 SHALL update paddle_y, moving and hit_wall one clock after the causing frame_tick or press.

Reset
REQ-024 SHALL, on rst high at a clk edge, set paddle_y=Y_INIT, state IDLE, counter 0, moving=0, hit_wall=0, speed level 1, overriding all other inputs including mid-glide.

Configuration
REQ-025 SHALL, with PADDLE_ACCEL_EN defined, keep speed level 1..3: each same-direction press while already moving that direction increments level (saturating at 3); step = STEP*level; level returns to 1 on IDLE or direction change.
REQ-026 SHALL, without PADDLE_ACCEL_EN, use step = STEP always and contain no speed level logic.

Verification
REQ-027 Reset mid-glide (y=240, MOVE_UP) -> next cycle paddle_y=260, moving=0, hit_wall=0.
REQ-028 From reset, btn_up then 10 frame_ticks -> y 256,252,...,228 after 8th tick, moving drops after 8th tick, y stays 228.
REQ-029 From y=8 moving up, two frame_ticks -> y=4, then y=0 with hit_wall one-cycle pulse, IDLE; third tick no change.
REQ-030 btn_up and btn_down high same cycle in IDLE, then 3 ticks -> paddle_y stays 260, moving=0.
REQ-031 btn_up, 3 ticks (y=248), btn_down coinciding with 4th tick -> y=244, then 8 ticks to y=276, IDLE.
REQ-032 PADDLE_ACCEL_EN defined: btn_down, btn_down, btn_down, then tick -> y 260 to 272; without macro same stimulus -> 264.

Source files
------------

// File: rtl/paddle_ctrl.sv
// paddle_ctrl -- vertical paddle position controller for a Pong-style game.
//
// A one-cycle button press starts a glide of GLIDE_FRAMES frame ticks in the
// pressed direction. On each frame tick the paddle moves by the current step.
// The paddle is clamped to the visible screen. Reaching a bound ends the glide
// and pulses hit_wall.
//
// Optional feature (macro PADDLE_ACCEL_EN):
//   Each repeated press in the direction the paddle is already moving raises a
//   speed level, saturating at 3. The step is STEP*level. The level returns to
//   1 when the paddle goes idle or changes direction.
//   Without the macro, the step is always STEP.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   frame_tick  one-cycle pulse, once per video frame
//   btn_up      one-cycle press pulse, move towards row 0
//   btn_down    one-cycle press pulse, move towards the bottom
//   freeze      level input; holds position, state and counter (serve/pause)
//   paddle_y    registered paddle top-edge row
//   moving      high while in MOVE_UP or MOVE_DOWN
//   hit_wall    one-cycle pulse when a move is clamped at a bound

module paddle_ctrl #(
  parameter int SCREEN_H     = 600,
  parameter int PADDLE_H     = 80,
  parameter int Y_INIT       = 260,
  parameter int STEP         = 4,
  parameter int GLIDE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        freeze,
  output logic [10:0] paddle_y,
  output logic        moving,
  output logic        hit_wall
);

  localparam int CW = $clog2(GLIDE_FRAMES + 1);
  localparam logic signed [11:0] Y_MAX_S = 12'(SCREEN_H - PADDLE_H);
  localparam logic [10:0]        Y_MAX_U = 11'(SCREEN_H - PADDLE_H);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        glide_cnt, glide_cnt_n;
  logic [10:0]          y_n;
  logic                 hit_n;
  logic                 press_up, press_down, press, tick_move;
  logic signed [11:0]   step_s, y_cur, y_sum;

  // A press needs exactly one button. Freeze masks presses and motion.
  assign press_up   = btn_up & ~btn_down & ~freeze;
  assign press_down = btn_down & ~btn_up & ~freeze;
  assign press      = press_up | press_down;
  assign tick_move  = frame_tick & ~freeze & (state != IDLE);
  assign moving     = (state != IDLE);

`ifdef PADDLE_ACCEL_EN
  logic [1:0] level, level_n;

  always_comb begin
    case (level)
      2'd2:    step_s = 12'(2 * STEP);
      2'd3:    step_s = 12'(3 * STEP);
      default: step_s = 12'(STEP);
    endcase
  end
`else
  assign step_s = 12'(STEP);
`endif

  // The sum is signed and one bit wider than paddle_y, so an overshoot past
  // row 0 shows up as negative instead of wrapping.
  assign y_cur = $signed({1'b0, paddle_y});
  assign y_sum = (state == MOVE_UP) ? (y_cur - step_s) : (y_cur + step_s);

  always_comb begin
    state_n     = state;
    glide_cnt_n = glide_cnt;
    y_n         = paddle_y;
    hit_n       = 1'b0;
`ifdef PADDLE_ACCEL_EN
    level_n     = level;
`endif

    // The move uses the direction from before this cycle.
    if (tick_move) begin
      if (state == MOVE_UP && y_sum <= 0) begin
        y_n         = '0;
        hit_n       = 1'b1;
        state_n     = IDLE;
        glide_cnt_n = '0;
      end else if (state == MOVE_DOWN && y_sum >= Y_MAX_S) begin
        y_n         = Y_MAX_U;
        hit_n       = 1'b1;
        state_n     = IDLE;
        glide_cnt_n = '0;
      end else begin
        y_n         = y_sum[10:0];
        glide_cnt_n = glide_cnt - 1'b1;
        if (glide_cnt == CW'(1))
          state_n = IDLE;
      end
    end

    // A press overrides the decrement or idle result of a coincident tick.
    if (press) begin
      state_n     = press_up ? MOVE_UP : MOVE_DOWN;
      glide_cnt_n = CW'(GLIDE_FRAMES);
`ifdef PADDLE_ACCEL_EN
      if ((press_up && state == MOVE_UP) || (press_down && state == MOVE_DOWN))
        level_n = (level == 2'd3) ? 2'd3 : level + 2'd1;
      else
        level_n = 2'd1;
`endif
    end

`ifdef PADDLE_ACCEL_EN
    if (state_n == IDLE)
      level_n = 2'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      glide_cnt <= '0;
      paddle_y  <= 11'(Y_INIT);
      hit_wall  <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      level     <= 2'd1;
`endif
    end else begin
      state     <= state_n;
      glide_cnt <= glide_cnt_n;
      paddle_y  <= y_n;
      hit_wall  <= hit_n;
`ifdef PADDLE_ACCEL_EN
      level     <= level_n;
`endif
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl -- directed testbench for paddle_ctrl with default parameters
// (screen 600, paddle 80, init row 260, step 4, glide 8).

module tb_paddle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        freeze = 1'b0;
  logic [10:0] paddle_y;
  logic        moving;
  logic        hit_wall;

  int checks = 0;
  int errors = 0;

  paddle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .freeze     (freeze),
    .paddle_y   (paddle_y),
    .moving     (moving),
    .hit_wall   (hit_wall)
  );

  always #5 clk = ~clk;

  // One clock with the given pulses. Outputs are sampled 1 time unit after the edge.
  task automatic drive_cycle(input logic up, input logic down, input logic tick);
    btn_up     = up;
    btn_down   = down;
    frame_tick = tick;
    @(posedge clk);
    #1;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (paddle_y !== 11'd260) begin errors++; $display("[TB] FAIL reset_y got %0d want 260", paddle_y); end
    checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL reset_moving got %b want 0", moving); end
    checks++; if (hit_wall !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit got %b want 0", hit_wall); end
  endtask

  task automatic test_glide();
    int exp_y;
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (moving !== 1'b1) begin errors++; $display("[TB] FAIL glide_start_moving got %b want 1", moving); end
    checks++; if (paddle_y !== 11'd260) begin errors++; $display("[TB] FAIL glide_start_y got %0d want 260", paddle_y); end
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b1);
      exp_y = (k <= 8) ? 260 - 4 * k : 228;
      checks++; if (paddle_y !== 11'(exp_y)) begin errors++; $display("[TB] FAIL glide_y tick %0d got %0d want %0d", k, paddle_y, exp_y); end
      checks++; if (moving !== (k < 8)) begin errors++; $display("[TB] FAIL glide_moving tick %0d got %b want %b", k, moving, (k < 8)); end
    end
  endtask

  task automatic test_reset_mid_glide();
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd240 || moving !== 1'b1) begin errors++; $display("[TB] FAIL midglide_pre got y=%0d mv=%b want y=240 mv=1", paddle_y, moving); end
    rst = 1'b1;
    btn_up = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn_up = 1'b0;
    frame_tick = 1'b0;
    checks++; if (paddle_y !== 11'd260) begin errors++; $display("[TB] FAIL midglide_rst_y got %0d want 260", paddle_y); end
    checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL midglide_rst_moving got %b want 0", moving); end
    checks++; if (hit_wall !== 1'b0) begin errors++; $display("[TB] FAIL midglide_rst_hit got %b want 0", hit_wall); end
  endtask

  task automatic test_top_wall();
    do_reset();
    // Move up 1 tick, reverse down for a full glide: 256 + 32 = 288.
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd288 || moving !== 1'b0) begin errors++; $display("[TB] FAIL top_setup got y=%0d mv=%b want y=288 mv=0", paddle_y, moving); end
    for (int r = 0; r < 8; r++) begin
      drive_cycle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) drive_cycle(1'b0, 1'b0, 1'b1);
    end
    checks++; if (paddle_y !== 11'd32 || moving !== 1'b0) begin errors++; $display("[TB] FAIL top_rounds got y=%0d mv=%b want y=32 mv=0", paddle_y, moving); end
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd8 || moving !== 1'b1) begin errors++; $display("[TB] FAIL top_y8 got y=%0d mv=%b want y=8 mv=1", paddle_y, moving); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd4 || hit_wall !== 1'b0 || moving !== 1'b1) begin errors++; $display("[TB] FAIL top_y4 got y=%0d hit=%b mv=%b want y=4 hit=0 mv=1", paddle_y, hit_wall, moving); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd0) begin errors++; $display("[TB] FAIL top_clamp_y got %0d want 0", paddle_y); end
    checks++; if (hit_wall !== 1'b1) begin errors++; $display("[TB] FAIL top_hit got %b want 1", hit_wall); end
    checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL top_idle got %b want 0", moving); end
    drive_cycle(1'b0, 1'b0, 1'b0);
    checks++; if (hit_wall !== 1'b0) begin errors++; $display("[TB] FAIL top_hit_pulse got %b want 0", hit_wall); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd0 || hit_wall !== 1'b0) begin errors++; $display("[TB] FAIL top_after got y=%0d hit=%b want y=0 hit=0", paddle_y, hit_wall); end
  endtask

  task automatic test_bottom_wall();
    do_reset();
    for (int r = 0; r < 8; r++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) drive_cycle(1'b0, 1'b0, 1'b1);
    end
    checks++; if (paddle_y !== 11'd516 || moving !== 1'b0) begin errors++; $display("[TB] FAIL bot_rounds got y=%0d mv=%b want y=516 mv=0", paddle_y, moving); end
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd520 || hit_wall !== 1'b1 || moving !== 1'b0) begin errors++; $display("[TB] FAIL bot_clamp got y=%0d hit=%b mv=%b want y=520 hit=1 mv=0", paddle_y, hit_wall, moving); end
    drive_cycle(1'b0, 1'b0, 1'b0);
    checks++; if (hit_wall !== 1'b0) begin errors++; $display("[TB] FAIL bot_hit_pulse got %b want 0", hit_wall); end
  endtask

  task automatic test_both_buttons();
    do_reset();
    drive_cycle(1'b1, 1'b1, 1'b0);
    checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL both_moving got %b want 0", moving); end
    for (int k = 1; k <= 3; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b1);
      checks++; if (paddle_y !== 11'd260 || moving !== 1'b0) begin errors++; $display("[TB] FAIL both_tick %0d got y=%0d mv=%b want y=260 mv=0", k, paddle_y, moving); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd248) begin errors++; $display("[TB] FAIL b2b_y248 got %0d want 248", paddle_y); end
    drive_cycle(1'b0, 1'b1, 1'b1);
    checks++; if (paddle_y !== 11'd244 || moving !== 1'b1) begin errors++; $display("[TB] FAIL b2b_coincide got y=%0d mv=%b want y=244 mv=1", paddle_y, moving); end
    for (int k = 0; k < 7; k++) drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd272 || moving !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tick7 got y=%0d mv=%b want y=272 mv=1", paddle_y, moving); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd276 || moving !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end got y=%0d mv=%b want y=276 mv=0", paddle_y, moving); end
  endtask

  task automatic test_freeze();
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1);
    freeze = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd252 || moving !== 1'b1 || hit_wall !== 1'b0) begin errors++; $display("[TB] FAIL freeze_hold got y=%0d mv=%b hit=%b want y=252 mv=1 hit=0", paddle_y, moving, hit_wall); end
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (paddle_y !== 11'd252 || moving !== 1'b1) begin errors++; $display("[TB] FAIL freeze_press got y=%0d mv=%b want y=252 mv=1", paddle_y, moving); end
    freeze = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'd248) begin errors++; $display("[TB] FAIL freeze_resume got %0d want 248", paddle_y); end
  endtask

  task automatic test_accel();
    int exp_y;
`ifdef PADDLE_ACCEL_EN
    exp_y = 272;
`else
    exp_y = 264;
`endif
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (paddle_y !== 11'(exp_y)) begin errors++; $display("[TB] FAIL accel_y got %0d want %0d", paddle_y, exp_y); end
  endtask

  initial begin
    #1;
    test_reset();
    test_glide();
    test_reset_mid_glide();
    test_top_wall();
    test_bottom_wall();
    test_both_buttons();
    test_back_to_back();
    test_freeze();
    test_accel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
